// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a fixed-latency 32-bit data memory.
// Latency: enable strobe 1 cycle after the request is sampled; ack MEM_LATENCY+2 cycles after it.
// Backpressure: requests are sampled only in IDLE; a request held high while busy waits its turn.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH  = 3,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [31:0]           a_wdata,
    output logic                  a_ack,
    output logic [31:0]           a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [31:0]           b_wdata,
    output logic                  b_ack,
    output logic [31:0]           b_rdata,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_write_index,
    output logic [31:0]           mem_write_data,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_read_index,
    input  logic [31:0]           mem_read_data,
    output logic                  busy,
    output logic                  grant_b
);

    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           cnt;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [31:0]             lat_wdata;
    logic                    last_grant;
    logic                    pick_b;
    logic                    cnt_last;

    // On contention the port that did not win last time goes next.
    assign pick_b   = b_req & (~a_req | ~last_grant);
    assign cnt_last = (cnt == CW'(1));

    assign busy            = (state != IDLE);
    assign mem_write_index = lat_addr;
    assign mem_read_index  = lat_addr;
    assign mem_write_data  = lat_wdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_write_enable = lat_we;
                mem_read_enable  = ~lat_we;
                state_nxt        = WAIT;
            end
            WAIT: begin
                if (cnt_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            grant_b    <= 1'b0;
            last_grant <= 1'b1;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        grant_b    <= pick_b;
                        last_grant <= pick_b;
                        lat_we     <= pick_b ? b_we    : a_we;
                        lat_addr   <= pick_b ? b_addr  : a_addr;
                        lat_wdata  <= pick_b ? b_wdata : a_wdata;
                    end
                end
                ISSUE: begin
                    cnt <= CW'(MEM_LATENCY);
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    // Read data is valid at this edge; writes leave both rdata registers alone.
                    if (cnt_last) begin
                        if (grant_b) begin
                            b_ack <= 1'b1;
                            if (!lat_we) begin
                                b_rdata <= mem_read_data;
                            end
                        end else begin
                            a_ack <= 1'b1;
                            if (!lat_we) begin
                                a_rdata <= mem_read_data;
                            end
                        end
                    end
                end
                DONE: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: cycle table for single transactions, plus
// hand sequences for contention, back-to-back requests, mid-transaction reset and late requests.
module tb_data_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        a_req, a_we, b_req, b_we;
    logic [2:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_write_enable, mem_read_enable;
    logic [2:0]  mem_write_index, mem_read_index;
    logic [31:0] mem_write_data, mem_read_data;
    logic        busy, grant_b;

    logic [31:0] mem [8];
    logic        mem_init;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] WVAL = 32'h12345678;

    always #5 CLK = ~CLK;

    data_mem_arbiter #(.ADDR_WIDTH(3), .MEM_LATENCY(2)) dut (
        .CLK(CLK), .RST(RST),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_write_enable(mem_write_enable), .mem_write_index(mem_write_index),
        .mem_write_data(mem_write_data), .mem_read_enable(mem_read_enable),
        .mem_read_index(mem_read_index), .mem_read_data(mem_read_data),
        .busy(busy), .grant_b(grant_b)
    );

    function automatic logic [31:0] word(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    endfunction

    // Memory model: one registered read stage, holds between strobes.
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= word(i);
        end else if (mem_write_enable) begin
            mem[mem_write_index] <= mem_write_data;
        end
        if (mem_read_enable) mem_read_data <= mem[mem_read_index];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    typedef struct {
        logic ar, aw; logic [2:0] aa; logic [31:0] ad;
        logic br, bw; logic [2:0] ba; logic [31:0] bd;
        logic re, we; logic [2:0] idx; logic [31:0] wd;
        logic aack, back; logic [31:0] ard, brd;
        logic bsy, gb;
    } vec_t;

    vec_t tbl [16];

    task automatic set_row(input int r,
                           input logic ar, input logic aw, input logic [2:0] aa, input logic [31:0] ad,
                           input logic br, input logic bw, input logic [2:0] ba, input logic [31:0] bd,
                           input logic re, input logic we, input logic [2:0] idx, input logic [31:0] wd,
                           input logic aack, input logic back, input logic [31:0] ard, input logic [31:0] brd,
                           input logic bsy, input logic gb);
        tbl[r] = '{ar, aw, aa, ad, br, bw, ba, bd, re, we, idx, wd, aack, back, ard, brd, bsy, gb};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, nack, ovl_en, ovl_ack, n_en, first, cnt_a, cnt_b;
        int ack_cyc [4];
        logic ack_gb [4];
        logic ack_isb [4];
        logic [31:0] ack_dat [4];

        // A reads 5; B writes WVAL to 2; A reads 2.
        set_row( 0, 1'b1,1'b0,3'd5,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0);
        set_row( 1, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b1,1'b0,3'd5,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0);
        set_row( 2, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd5,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0);
        set_row( 3, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd5,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0);
        set_row( 4, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd5,32'h0, 1'b1,1'b0,32'hDEADBEEF,32'h0, 1'b1,1'b0);
        set_row( 5, 1'b0,1'b0,3'd0,32'h0, 1'b1,1'b1,3'd2,WVAL,  1'b0,1'b0,3'd5,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b0,1'b0);
        set_row( 6, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b1,3'd2,WVAL,  1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b1,1'b1);
        set_row( 7, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd2,WVAL,  1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b1,1'b1);
        set_row( 8, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd2,WVAL,  1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b1,1'b1);
        set_row( 9, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd2,WVAL,  1'b0,1'b1,32'hDEADBEEF,32'h0, 1'b1,1'b1);
        set_row(10, 1'b1,1'b0,3'd2,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd2,WVAL,  1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b0,1'b1);
        set_row(11, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b1,1'b0,3'd2,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b1,1'b0);
        set_row(12, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd2,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b1,1'b0);
        set_row(13, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd2,32'h0, 1'b0,1'b0,32'hDEADBEEF,32'h0, 1'b1,1'b0);
        set_row(14, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd2,32'h0, 1'b1,1'b0,WVAL,32'h0,  1'b1,1'b0);
        set_row(15, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0,32'h0, 1'b0,1'b0,3'd2,32'h0, 1'b0,1'b0,WVAL,32'h0,  1'b0,1'b0);

        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        mem_init = 1'b1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0; mem_init = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_we",    32'(mem_write_enable), 32'h0);
        chk("rst_re",    32'(mem_read_enable), 32'h0);
        chk("rst_widx",  32'(mem_write_index), 32'h0);
        chk("rst_ridx",  32'(mem_read_index), 32'h0);
        chk("rst_wdata", mem_write_data, 32'h0);
        chk("rst_acks",  32'({a_ack, b_ack}), 32'h0);
        chk("rst_ard",   a_rdata, 32'h0);
        chk("rst_brd",   b_rdata, 32'h0);
        chk("rst_gb",    32'(grant_b), 32'h0);
        @(posedge CLK); #1;

        // Cycle table
        for (int r = 0; r < 16; r++) begin
            a_req = tbl[r].ar; a_we = tbl[r].aw; a_addr = tbl[r].aa; a_wdata = tbl[r].ad;
            b_req = tbl[r].br; b_we = tbl[r].bw; b_addr = tbl[r].ba; b_wdata = tbl[r].bd;
            @(negedge CLK);
            chk($sformatf("row%0d re", r),   32'(mem_read_enable),  32'(tbl[r].re));
            chk($sformatf("row%0d we", r),   32'(mem_write_enable), 32'(tbl[r].we));
            chk($sformatf("row%0d ridx", r), 32'(mem_read_index),   32'(tbl[r].idx));
            chk($sformatf("row%0d widx", r), 32'(mem_write_index),  32'(tbl[r].idx));
            chk($sformatf("row%0d wd", r),   mem_write_data,        tbl[r].wd);
            chk($sformatf("row%0d aack", r), 32'(a_ack),            32'(tbl[r].aack));
            chk($sformatf("row%0d back", r), 32'(b_ack),            32'(tbl[r].back));
            chk($sformatf("row%0d ard", r),  a_rdata,               tbl[r].ard);
            chk($sformatf("row%0d brd", r),  b_rdata,               tbl[r].brd);
            chk($sformatf("row%0d busy", r), 32'(busy),             32'(tbl[r].bsy));
            chk($sformatf("row%0d gb", r),   32'(grant_b),          32'(tbl[r].gb));
            @(posedge CLK); #1;
        end

        // Both ports held high from reset: A, B, A, B every 5 cycles
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        do_reset();
        @(negedge CLK);
        a_req = 1'b1; a_addr = 3'd1; b_req = 1'b1; b_addr = 3'd3;
        nack = 0; ovl_en = 0; ovl_ack = 0; n_en = 0;
        for (int k = 0; k < 4; k++) begin
            ack_cyc[k] = -1; ack_gb[k] = 1'b0; ack_isb[k] = 1'b0; ack_dat[k] = '0;
        end
        for (c = 1; c <= 30; c++) begin
            @(negedge CLK);
            if (mem_read_enable && mem_write_enable) ovl_en++;
            if (a_ack && b_ack) ovl_ack++;
            if (mem_read_enable || mem_write_enable) n_en++;
            if ((a_ack || b_ack) && nack < 4) begin
                ack_cyc[nack] = c; ack_gb[nack] = grant_b; ack_isb[nack] = b_ack;
                ack_dat[nack] = b_ack ? b_rdata : a_rdata;
                nack++;
                if (nack == 4) begin a_req = 1'b0; b_req = 1'b0; end
            end
        end
        chk("rr_nack", 32'(nack), 32'd4);
        chk("rr_en_overlap", 32'(ovl_en), 32'd0);
        chk("rr_ack_overlap", 32'(ovl_ack), 32'd0);
        chk("rr_n_enables", 32'(n_en), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_ack%0d_cycle", k), 32'(ack_cyc[k]), 32'(4 + 5 * k));
            chk($sformatf("rr_ack%0d_grant", k), 32'(ack_gb[k]), 32'(k % 2));
            chk($sformatf("rr_ack%0d_port", k), 32'(ack_isb[k]), 32'(k % 2));
            chk($sformatf("rr_ack%0d_data", k), ack_dat[k], (k % 2 == 1) ? word(3) : word(1));
        end

        // A alone held high for reads of 0, 1, 2
        @(negedge CLK);
        a_req = 1'b1; a_addr = 3'd0;
        nack = 0; cnt_b = 0;
        for (c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (b_ack) cnt_b++;
            if (a_ack && nack < 3) begin
                ack_cyc[nack] = c; ack_dat[nack] = a_rdata;
                nack++;
                a_addr = 3'(nack);
                if (nack == 3) a_req = 1'b0;
            end
        end
        chk("b2b_nack", 32'(nack), 32'd3);
        chk("b2b_no_back", 32'(cnt_b), 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b2b_ack%0d_cycle", k), 32'(ack_cyc[k]), 32'(4 + 5 * k));
        end
        chk("b2b_data0", ack_dat[0], word(0));
        chk("b2b_data1", ack_dat[1], word(1));
        chk("b2b_data2", ack_dat[2], WVAL);

        // Reset during WAIT of an A read, then contention goes to A
        @(negedge CLK);
        a_req = 1'b1; a_addr = 3'd5;
        first = -1; cnt_a = 0; cnt_b = 0;
        for (c = 1; c <= 12; c++) begin
            @(negedge CLK);
            if (c == 1) a_req = 1'b0;
            if (c == 2) begin
                chk("rstw_busy_before", 32'(busy), 32'h1);
                RST = 1'b1;
            end
            if (c == 3) begin
                RST = 1'b0;
                chk("rstw_busy", 32'(busy), 32'h0);
                chk("rstw_aack", 32'(a_ack), 32'h0);
                chk("rstw_ard", a_rdata, 32'h0);
                a_req = 1'b1; b_req = 1'b1;
            end
            if (c == 4) begin
                chk("rstw_grant", 32'(grant_b), 32'h0);
                chk("rstw_re", 32'(mem_read_enable), 32'h1);
                a_req = 1'b0; b_req = 1'b0;
            end
            if (c >= 3 && a_ack) begin
                cnt_a++;
                if (first < 0) first = c;
            end
            if (c >= 3 && b_ack) cnt_b++;
        end
        chk("rstw_n_aack", 32'(cnt_a), 32'd1);
        chk("rstw_aack_cycle", 32'(first), 32'd7);
        chk("rstw_n_back", 32'(cnt_b), 32'd0);

        // B request arrives while A is busy
        @(negedge CLK);
        a_req = 1'b1; a_addr = 3'd4; b_addr = 3'd3; b_we = 1'b0;
        first = -1; cnt_b = 0; ack_cyc[0] = -1; ack_dat[0] = '0; ack_dat[1] = '0;
        for (c = 1; c <= 15; c++) begin
            @(negedge CLK);
            if (c == 1) a_req = 1'b0;
            if (c == 2) b_req = 1'b1;
            if (c == 6) chk("late_grant_b", 32'(grant_b), 32'h1);
            if (a_ack && ack_cyc[0] < 0) begin ack_cyc[0] = c; ack_dat[0] = a_rdata; end
            if (b_ack) begin
                cnt_b++;
                if (first < 0) begin first = c; ack_dat[1] = b_rdata; end
                b_req = 1'b0;
            end
        end
        chk("late_aack_cycle", 32'(ack_cyc[0]), 32'd4);
        chk("late_adata", ack_dat[0], word(4));
        chk("late_back_cycle", 32'(first), 32'd9);
        chk("late_n_back", 32'(cnt_b), 32'd1);
        chk("late_bdata", ack_dat[1], word(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
